pc_int_nest: RTL and testbench
==============================

// Module: pc_int_nest
// PURPOSE
//  Program-counter register with multi-source, prioritised, nestable interrupt entry and RFE return.
//  Sits in the single-cycle CPU fetch path. Takes pc_next from the next-PC mux and drives pc to
//  instruction memory. Handles the interrupt vector, the EPC stack and the priority level in one block.
// PARAMETERS
//  WIDTH       32      PC / address width
//  NUM_IRQ     4       interrupt lines; index 0 = highest priority
//  NEST_DEPTH  2       EPC stack entries (max nesting levels)
//  RESET_PC    0       pc value after reset
//  VEC_BASE    'h4     address of vector for irq 0
//  VEC_STRIDE  4       byte distance between consecutive vectors
// PORTS
//  clk        in   1                       clock, rising edge
//  reset      in   1                       async, active-low (0 = reset)
//  en         in   1                       pc update enable; 0 = stall, all state holds
//  ie         in   1                       global interrupt enable
//  rfe        in   1                       return-from-exception, sampled when en=1
//  irq        in   NUM_IRQ                 level-sensitive requests
//  irq_mask   in   NUM_IRQ                 1 = line masked
//  pc_next    in   WIDTH                   sequential/branch target for this cycle
//  pc         out  WIDTH                   current PC (registered)
//  irq_ack    out  NUM_IRQ                 one-hot, 1-cycle pulse on the cycle an irq is taken
//  cur_level  out  $clog2(NUM_IRQ+1)       active priority; NUM_IRQ = not in ISR
//  depth      out  $clog2(NEST_DEPTH+1)    EPC stack occupancy
//  rfe_err    out  1                       1-cycle pulse: rfe with empty stack
// BEHAVIOUR
//  Reset (async, reset=0):
//   - pc=RESET_PC, cur_level=NUM_IRQ, depth=0, irq_ack=0, rfe_err=0; stack contents don't-care.
//  All state changes happen on posedge clk with en=1 only. en=0 holds everything.
//   - irq_ack and rfe_err are forced to 0 while en=0.
//  Candidate: lowest index i with irq[i] & ~irq_mask[i] (combinational priority encode).
//  Take condition: en & ie & ~rfe & candidate exists & i < cur_level & depth < NEST_DEPTH.
//  Take (one cycle, zero-latency entry):
//   - push {pc_next, cur_level}; depth+1.
//   - pc <= VEC_BASE + i*VEC_STRIDE, truncated to WIDTH; cur_level <= i; irq_ack[i]=1 for that cycle.
//  rfe with depth>0:
//   - pop; pc <= saved pc; cur_level <= saved level; depth-1.
//  rfe with depth=0:
//   - pc <= pc_next; rfe_err=1; level and depth unchanged.
//  Priority of events:
//   - rfe and a takeable irq in the same cycle: rfe wins. The irq is re-evaluated the next cycle
//     (levels are not latched).
//  Equal or lower priority (i >= cur_level): not taken; the request stays pending on the line.
//  Stack full (depth=NEST_DEPTH): no further entry regardless of priority. Not an error.
//  Otherwise: pc <= pc_next.
//  Reset mid-ISR: the stack is abandoned; state returns to reset values immediately.
//  Vector math is unsigned, modulo 2^WIDTH; no overflow flag.
// TESTING
//  1 Reset: reset=0 with irq=all 1s -> pc=0, cur_level=4, depth=0, no ack. Release reset ->
//    pc follows pc_next (0x10, 0x14).
//  2 Single entry/exit: pc_next=0x100, irq[2]=1, ie=1 -> pc=0xC, irq_ack=4'b0100, cur_level=2,
//    depth=1. Later rfe=1 -> pc=0x100, cur_level=4, depth=0.
//  3 Nesting/priority: in irq2 ISR, assert irq[3] -> ignored. Assert irq[0] with pc_next=0x20 ->
//    pc=0x4, depth=2. Assert irq[1] -> blocked because the stack is full. Two rfe -> pc=0x20, then
//    pc = the EPC saved at step 2 entry.
//  4 Mask/ie/stall: irq[1]=1 with irq_mask[1]=1, or ie=0, or en=0 -> no ack, pc unchanged when en=0.
//    Unmask with en=1 -> taken.
//  5 Conflicts: rfe=1 and irq[0]=1 at depth=1 -> pop happens, no ack; irq[0] taken next cycle.
//    rfe at depth=0 with pc_next=0x40 -> pc=0x40, rfe_err=1.
//  6 Reset mid-ISR: reset=0 asynchronously while depth=2 -> immediate pc=0, depth=0, cur_level=4.

Source files
------------

// File: rtl/pc_int_nest.sv
// rtl/pc_int_nest.sv - PC register with prioritised nestable interrupt entry and RFE return
module pc_int_nest #(
  parameter int              WIDTH      = 32,
  parameter int              NUM_IRQ    = 4,
  parameter int              NEST_DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] VEC_BASE  = 'h4,
  parameter logic [WIDTH-1:0] VEC_STRIDE = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              ie,
  input  logic                              rfe,
  input  logic [NUM_IRQ-1:0]                irq,
  input  logic [NUM_IRQ-1:0]                irq_mask,
  input  logic [WIDTH-1:0]                  pc_next,
  output logic [WIDTH-1:0]                  pc,
  output logic [NUM_IRQ-1:0]                irq_ack,
  output logic [$clog2(NUM_IRQ+1)-1:0]      cur_level,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   depth,
  output logic                              rfe_err
);

  localparam int LW = $clog2(NUM_IRQ + 1);
  localparam int DW = $clog2(NEST_DEPTH + 1);

  logic [NUM_IRQ-1:0] req;
  logic               cand_valid;
  logic [LW-1:0]      cand_idx;
  logic               take;
  logic               pop;
  logic [WIDTH-1:0]   vec_addr;
  logic [WIDTH-1:0]   top_pc;
  logic [LW-1:0]      top_lvl;

  // EPC stack storage; contents are don't-care after reset so no reset here
  logic [WIDTH-1:0]   epc_pc  [NEST_DEPTH];
  logic [LW-1:0]      epc_lvl [NEST_DEPTH];

  assign req = irq & ~irq_mask;

  // Priority encode: lowest unmasked requesting line wins
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        cand_valid = 1'b1;
        cand_idx   = LW'(k);
      end
    end
  end

  // rfe outranks entry; reset gating keeps the pulses low while held in reset
  assign take = reset & en & ie & ~rfe & cand_valid &
                (cand_idx < cur_level) & (depth < DW'(NEST_DEPTH));
  assign pop  = en & rfe & (depth != '0);

  assign vec_addr = VEC_BASE + WIDTH'(cand_idx) * VEC_STRIDE;
  assign irq_ack  = take ? (NUM_IRQ'(1) << cand_idx) : '0;
  assign rfe_err  = reset & en & rfe & (depth == '0);

  // Read the top-of-stack entry (slot depth-1)
  always_comb begin
    top_pc  = '0;
    top_lvl = '0;
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (depth == DW'(k + 1)) begin
        top_pc  = epc_pc[k];
        top_lvl = epc_lvl[k];
      end
    end
  end

  // Push return PC and level into slot depth on interrupt entry
  always_ff @(posedge clk) begin
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (take && depth == DW'(k)) begin
        epc_pc[k]  <= pc_next;
        epc_lvl[k] <= cur_level;
      end
    end
  end

  // PC, level and depth update; en=0 holds everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      cur_level <= LW'(NUM_IRQ);
      depth     <= '0;
    end else if (en) begin
      if (pop) begin
        pc        <= top_pc;
        cur_level <= top_lvl;
        depth     <= depth - 1'b1;
      end else if (take) begin
        pc        <= vec_addr;
        cur_level <= cand_idx;
        depth     <= depth + 1'b1;
      end else begin
        pc        <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_pc_int_nest.sv
// tb/tb_pc_int_nest.sv - directed vector bench for pc_int_nest
module tb_pc_int_nest;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, ie, rfe;
  logic [3:0]  irq, irq_mask;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [3:0]  irq_ack;
  logic [2:0]  cur_level;
  logic [1:0]  depth;
  logic        rfe_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_int_nest dut (
    .clk(clk), .reset(reset), .en(en), .ie(ie), .rfe(rfe),
    .irq(irq), .irq_mask(irq_mask), .pc_next(pc_next),
    .pc(pc), .irq_ack(irq_ack), .cur_level(cur_level),
    .depth(depth), .rfe_err(rfe_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, ie, rfe;
    logic [3:0]  irq, mask;
    logic [31:0] pcn;
    logic [3:0]  e_ack;
    logic        e_err;
    logic [31:0] e_pc;
    logic [2:0]  e_lvl;
    logic [1:0]  e_dep;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic v_en, logic v_ie, logic v_rfe, logic [3:0] v_irq,
                              logic [3:0] v_mask, logic [31:0] v_pcn, logic [3:0] v_ack,
                              logic v_err, logic [31:0] v_pc, logic [2:0] v_lvl,
                              logic [1:0] v_dep);
    vec_t v;
    v.en = v_en; v.ie = v_ie; v.rfe = v_rfe; v.irq = v_irq; v.mask = v_mask;
    v.pcn = v_pcn; v.e_ack = v_ack; v.e_err = v_err; v.e_pc = v_pc;
    v.e_lvl = v_lvl; v.e_dep = v_dep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at posedge+1, check pulses at negedge, check registered state at next posedge+1
  task automatic apply(input vec_t v, input string tag);
    en = v.en; ie = v.ie; rfe = v.rfe; irq = v.irq; irq_mask = v.mask; pc_next = v.pcn;
    @(negedge clk);
    chk({tag, ".ack"}, 32'(irq_ack), 32'(v.e_ack));
    chk({tag, ".err"}, 32'(rfe_err), 32'(v.e_err));
    @(posedge clk);
    #1;
    chk({tag, ".pc"},  pc, v.e_pc);
    chk({tag, ".lvl"}, 32'(cur_level), 32'(v.e_lvl));
    chk({tag, ".dep"}, 32'(depth), 32'(v.e_dep));
  endtask

  initial begin
    //                en ie rfe irq      mask     pc_next  ack      err pc       lvl dep
    vecs[0]  = mk(1, 1, 0, 4'b0000, 4'b0000, 32'h10,  4'b0000, 0, 32'h10,  4, 0);
    vecs[1]  = mk(1, 1, 0, 4'b0000, 4'b0000, 32'h14,  4'b0000, 0, 32'h14,  4, 0);
    vecs[2]  = mk(1, 1, 0, 4'b0100, 4'b0000, 32'h100, 4'b0100, 0, 32'hC,   2, 1);
    vecs[3]  = mk(1, 1, 0, 4'b1100, 4'b0000, 32'h10,  4'b0000, 0, 32'h10,  2, 1);
    vecs[4]  = mk(1, 1, 0, 4'b1101, 4'b0000, 32'h20,  4'b0001, 0, 32'h4,   0, 2);
    vecs[5]  = mk(1, 1, 0, 4'b0010, 4'b0000, 32'h24,  4'b0000, 0, 32'h24,  0, 2);
    vecs[6]  = mk(1, 1, 1, 4'b0000, 4'b0000, 32'h50,  4'b0000, 0, 32'h20,  2, 1);
    vecs[7]  = mk(1, 1, 1, 4'b0000, 4'b0000, 32'h54,  4'b0000, 0, 32'h100, 4, 0);
    vecs[8]  = mk(1, 1, 0, 4'b0010, 4'b0010, 32'h30,  4'b0000, 0, 32'h30,  4, 0);
    vecs[9]  = mk(1, 0, 0, 4'b0010, 4'b0000, 32'h34,  4'b0000, 0, 32'h34,  4, 0);
    vecs[10] = mk(0, 1, 0, 4'b0010, 4'b0000, 32'h99,  4'b0000, 0, 32'h34,  4, 0);
    vecs[11] = mk(0, 1, 1, 4'b0000, 4'b0000, 32'h98,  4'b0000, 0, 32'h34,  4, 0);
    vecs[12] = mk(1, 1, 0, 4'b0010, 4'b0000, 32'h38,  4'b0010, 0, 32'h8,   1, 1);
    vecs[13] = mk(1, 1, 1, 4'b0001, 4'b0000, 32'h70,  4'b0000, 0, 32'h38,  4, 0);
    vecs[14] = mk(1, 1, 0, 4'b0001, 4'b0000, 32'h3C,  4'b0001, 0, 32'h4,   0, 1);
    vecs[15] = mk(1, 1, 1, 4'b0000, 4'b0000, 32'h0,   4'b0000, 0, 32'h3C,  4, 0);
    vecs[16] = mk(1, 1, 1, 4'b0000, 4'b0000, 32'h40,  4'b0000, 1, 32'h40,  4, 0);
    vecs[17] = mk(1, 1, 0, 4'b1000, 4'b0000, 32'h200, 4'b1000, 0, 32'h10,  3, 1);
    vecs[18] = mk(1, 1, 0, 4'b0100, 4'b0000, 32'h204, 4'b0100, 0, 32'hC,   2, 2);
    vecs[19] = mk(1, 1, 0, 4'b0001, 4'b0000, 32'h208, 4'b0000, 0, 32'h208, 2, 2);

    reset = 1'b1; en = 1'b1; ie = 1'b1; rfe = 1'b0;
    irq = 4'hF; irq_mask = 4'h0; pc_next = 32'h10;
    #3 reset = 1'b0;
    #1;
    chk("rst.pc",  pc, 32'h0);
    chk("rst.lvl", 32'(cur_level), 32'd4);
    chk("rst.dep", 32'(depth), 32'd0);
    chk("rst.ack", 32'(irq_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold.pc",  pc, 32'h0);
    chk("rst_hold.ack", 32'(irq_ack), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset mid-ISR at depth 2, away from any clock edge
    #2 reset = 1'b0;
    #1;
    chk("midrst.pc",  pc, 32'h0);
    chk("midrst.lvl", 32'(cur_level), 32'd4);
    chk("midrst.dep", 32'(depth), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Clean operation after reset: follow, enter, return
    apply(mk(1, 1, 0, 4'b0000, 4'b0000, 32'h14,  4'b0000, 0, 32'h14,  4, 0), "post0");
    apply(mk(1, 1, 0, 4'b0100, 4'b0000, 32'h300, 4'b0100, 0, 32'hC,   2, 1), "post1");
    apply(mk(1, 1, 1, 4'b0000, 4'b0000, 32'h304, 4'b0000, 0, 32'h300, 4, 0), "post2");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
